dpram_arbiter: RTL and testbench
================================

Name: dpram_arbiter

Overview:
Two-requester arbiter and access sequencer for the single data port of the shared dpram. Requester 0 is the core MEM-stage data port and requester 1 is the DMA/debug master. The block grants the port round-robin and issues reads and full-word writes in one cycle. Sub-word writes run as a two-cycle read-modify-write, so requesters never merge bytes themselves.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; byte-enable width BE_W = DATA_WIDTH/8 (only 32 supported)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m0_req_i  in  1  requester 0 access request; held until granted
m0_we_i  in  1  1 = write, 0 = read
m0_addr_i  in  ADDR_WIDTH  byte address
m0_wdata_i  in  DATA_WIDTH  write data, already lane-aligned
m0_be_i  in  BE_W  byte enables, writes only
m0_gnt_o  out  1  request accepted this cycle
m0_rvalid_o  out  1  read data valid, one cycle after read grant
m0_rdata_o  out  DATA_WIDTH  read data
m1_*  same set as m0_* for requester 1
ram_ce_o  out  1  dpram chip enable
ram_we_o  out  1  dpram write enable
ram_addr_o  out  ADDR_WIDTH  word address (byte address with [1:0] forced to 0)
ram_wdata_o  out  DATA_WIDTH  dpram write data
ram_rdata_i  in  DATA_WIDTH  dpram read data, valid the cycle after a ce&!we access

Behaviour:
- Single clock domain, clk_i. Reset is synchronous and active-high on rst_i.
- While rst_i=1, all outputs are forced to 0: gnt, rvalid, rdata, ram_ce, ram_we, ram_addr, ram_wdata.
- On reset: state=ARB, rr_last=1 (requester 0 wins the first contention), rvalid pipe cleared.
- States:
  - ARB: arbitration and issue.
  - RMW_WR: write phase of a partial write.
- ARB arbitration:
  - Exactly one gnt, asserted combinationally in the issue cycle.
  - Single requester: that requester is granted.
  - Both requesting: grant goes to the requester != rr_last.
  - rr_last is updated to the winner on every grant.
- Granted read: ram_ce=1, ram_we=0, ram_addr from the winner. Next cycle: winner's rvalid=1 and rdata=ram_rdata_i. Back-to-back reads sustain 1 per cycle.
- Granted write, be=4'b1111: ram_ce=1, ram_we=1, ram_wdata=wdata in the grant cycle. No rvalid. Stay in ARB.
- Granted write, be=4'b0000: gnt=1, no RAM access, no rvalid. Stay in ARB.
- Granted write, any other be:
  - Grant cycle: ram_ce=1, ram_we=0 (read phase). Latch owner, addr, wdata, be.
  - Go to RMW_WR.
- RMW_WR:
  - ram_ce=1, ram_we=1, addr=latched addr.
  - Lane i of ram_wdata = be[i] ? wdata lane i : ram_rdata_i lane i.
  - No gnt to either requester. No rvalid. Next state ARB.
- rvalid/rdata are routed only to the owner of the read. The other requester sees rvalid=0 and rdata=0.
- A read granted in the cycle after RMW_WR observes the merged data.
- Ordering: accesses execute in grant order. No reordering, no write buffering.
- Reset during RMW_WR: the write phase is not performed, state returns to ARB, and the latched request is discarded.
- Reset coincident with a read grant: no rvalid follows.
- Requests that drop before grant are legal and are ignored.
- Address bits [1:0] never reach the RAM.

Decomposition:
- Shared defines header holds:
  - ARB/RMW_WR state encodings
  - BE_FULL (4'b1111) and BE_NONE
  - requester IDs REQ_CORE=0 and REQ_EXT=1
- One natural sub-module: rr_arb2. It holds the 2-way round-robin winner logic and rr_last register: inputs req[1:0] and an advance strobe, outputs gnt[1:0].
- Byte-lane merge stays inline.

Test Plan:
- Reset, then m0 read at 0x10 with RAM word 0xDEADBEEF -> m0_gnt=1 in cycle 0; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- m0 and m1 both request reads continuously for 4 cycles -> grants alternate m0,m1,m0,m1; each rvalid lands one cycle after its grant to the correct owner.
- m1 write addr 0x20, be=4'b0010, wdata=0x0000AB00, RAM word 0x11223344 -> 2-cycle sequence (read, then write 0x1122AB44). m0 request held meanwhile is granted only in the cycle after RMW_WR.
- m0 full write 0x20 data 0xCAFEF00D, then m0 read 0x20 next cycle -> single-cycle write, read returns 0xCAFEF00D; zero-be write produces gnt with ram_ce=0.
- Assert rst_i during RMW_WR (RAM word 0x11223344, be=4'b0001) -> no ram_we pulse, word unchanged; after reset, contention grants m0 first.
- Address 0x23 read -> ram_addr_o=0x20.

Source files
------------

// File: rtl/dpram_arbiter_pkg.sv
// Shared types and constants for the dpram data-port arbiter.
package dpram_arbiter_pkg;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_EXT  = 1'b1;

endpackage

// File: rtl/dpram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last winner held in rr_last.
module rr_arb2
  import dpram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On contention the requester that did not win last time goes first.
      2'b11:   gnt = (rr_last == REQ_EXT) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= REQ_EXT;
    end else if (advance && (gnt != 2'b00)) begin
      rr_last <= gnt[1];
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Arbitrates core and DMA/debug requesters onto the single dpram data port;
// reads and full writes issue in one cycle, sub-word writes run as read-modify-write.
module dpram_arbiter
  import dpram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int BE_W = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic [BE_W-1:0]       m0_be_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic [BE_W-1:0]       m1_be_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                state;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_W-1:0]       lat_be;
  logic [1:0]            rd_pend;

  logic                  in_arb;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  granted;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BE_W-1:0]       w_be;
  logic                  is_rd;
  logic                  is_full;
  logic                  is_part;
  logic [ADDR_WIDTH-1:0] acc_addr;

  // No new grants while the write phase of a merge owns the port.
  assign in_arb  = (state == ST_ARB) && !rst_i;
  assign req     = {m1_req_i, m0_req_i} & {2{in_arb}};
  assign granted = |gnt;

  rr_arb2 u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req),
    .advance (granted),
    .gnt     (gnt)
  );

  assign w_we    = gnt[1] ? m1_we_i    : m0_we_i;
  assign w_addr  = gnt[1] ? m1_addr_i  : m0_addr_i;
  assign w_wdata = gnt[1] ? m1_wdata_i : m0_wdata_i;
  assign w_be    = gnt[1] ? m1_be_i    : m0_be_i;

  assign is_rd   = granted && !w_we;
  assign is_full = granted && w_we && (w_be == BE_FULL);
  assign is_part = granted && w_we && (w_be != BE_FULL) && (w_be != BE_NONE);

  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    acc_addr    = '0;
    ram_wdata_o = '0;
    if ((state == ST_RMW_WR) && !rst_i) begin
      ram_ce_o = 1'b1;
      ram_we_o = 1'b1;
      acc_addr = lat_addr;
      for (int i = 0; i < BE_W; i++) begin
        ram_wdata_o[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : ram_rdata_i[8*i +: 8];
      end
    end else if (is_rd || is_part) begin
      ram_ce_o = 1'b1;
      acc_addr = w_addr;
    end else if (is_full) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = 1'b1;
      acc_addr    = w_addr;
      ram_wdata_o = w_wdata;
    end
  end

  assign ram_addr_o = acc_addr & WORD_MASK;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_ARB;
      rd_pend   <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      rd_pend <= is_rd ? gnt : 2'b00;
      case (state)
        ST_ARB: begin
          if (is_part) begin
            state     <= ST_RMW_WR;
            lat_addr  <= w_addr;
            lat_wdata <= w_wdata;
            lat_be    <= w_be;
          end
        end
        ST_RMW_WR: state <= ST_ARB;
        default:   state <= ST_ARB;
      endcase
    end
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rd_pend[0] && !rst_i;
  assign m1_rvalid_o = rd_pend[1] && !rst_i;
  assign m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_dpram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  logic [31:0] mem [0:15] = '{32'hA0A00000, 32'hB1B10004, 32'h0, 32'h0,
                              32'hDEADBEEF, 32'h0, 32'h0, 32'h0,
                              32'h11223344, 32'h0, 32'h11223344, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0};
  int we_cnt = 0;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int we_before;

  always #5 clk = ~clk;

  dpram_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_be_i(m0_be), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_be_i(m1_be), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Synchronous RAM: read data appears the cycle after a ce&!we access.
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      mem[ram_addr[5:2]] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (ram_ce && !ram_we) ram_rdata <= mem[ram_addr[5:2]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pops the oldest expected read return.
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {62'h0, m1_rvalid, m0_rvalid}, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rv_owner", {62'h0, m1_rvalid, m0_rvalid}, e.owner ? 64'h2 : 64'h1);
        check("rdata", e.owner ? {32'h0, m1_rdata} : {32'h0, m0_rdata}, {32'h0, e.data});
        check("rdata_other", e.owner ? {32'h0, m0_rdata} : {32'h0, m1_rdata}, 64'h0);
      end
    end
  end

  task automatic cyc(input logic r0, input logic we0, input logic [31:0] a0,
                     input logic [31:0] d0, input logic [3:0] be0,
                     input logic r1, input logic we1, input logic [31:0] a1,
                     input logic [31:0] d1, input logic [3:0] be1);
    @(posedge clk); #1;
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0; m0_be = be0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1; m1_be = be1;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  // Reset is held with an m0 read pending, which must be neither granted nor answered.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
    @(negedge clk);
    check("rst_quiet", {56'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_ce, ram_we,
                        (ram_addr != 0), (ram_wdata != 0)}, 64'h0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
    do_reset();

    // Single read from m0.
    cyc(1, 0, 32'h10, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    check("rd_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h1);
    check("rd_ram", {30'h0, ram_ce, ram_we, ram_addr}, {30'h0, 2'b10, 32'h10});
    sb.push_back('{1'b0, 32'hDEADBEEF});
    idle();

    // Continuous contention after reset alternates m0, m1, m0, m1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h00, 32'h0, 4'h0, 1, 0, 32'h04, 32'h0, 4'h0);
      check("rr_gnt", {62'h0, m1_gnt, m0_gnt}, (i % 2 == 0) ? 64'h1 : 64'h2);
      check("rr_addr", {32'h0, ram_addr}, (i % 2 == 0) ? 64'h0 : 64'h4);
      if (i % 2 == 0) sb.push_back('{1'b0, 32'hA0A00000});
      else            sb.push_back('{1'b1, 32'hB1B10004});
    end
    idle();

    // m1 partial write: read phase, then merged write; held m0 waits it out.
    cyc(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h20, 32'h0000AB00, 4'b0010);
    check("rmw_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h2);
    check("rmw_rd", {30'h0, ram_ce, ram_we, ram_addr}, {30'h0, 2'b10, 32'h20});
    cyc(1, 0, 32'h20, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    check("rmw_nogo", {62'h0, m1_gnt, m0_gnt}, 64'h0);
    check("rmw_wr", {30'h0, ram_ce, ram_we, ram_addr}, {30'h0, 2'b11, 32'h20});
    check("rmw_wdata", {32'h0, ram_wdata}, {32'h0, 32'h1122AB44});
    cyc(1, 0, 32'h20, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    check("rmw_after_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h1);
    check("rmw_mem", {32'h0, mem[8]}, {32'h0, 32'h1122AB44});
    sb.push_back('{1'b0, 32'h1122AB44});

    // Full write then read-back, then a zero-enable write.
    cyc(1, 1, 32'h20, 32'hCAFEF00D, 4'b1111, 0, 0, 32'h0, 32'h0, 4'h0);
    check("full_gnt", {63'h0, m0_gnt}, 64'h1);
    check("full_wr", {30'h0, ram_ce, ram_we, ram_wdata}, {30'h0, 2'b11, 32'hCAFEF00D});
    cyc(1, 0, 32'h20, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    check("full_rd_gnt", {63'h0, m0_gnt}, 64'h1);
    sb.push_back('{1'b0, 32'hCAFEF00D});
    cyc(1, 1, 32'h24, 32'h55555555, 4'b0000, 0, 0, 32'h0, 32'h0, 4'h0);
    check("be0_gnt", {63'h0, m0_gnt}, 64'h1);
    check("be0_ram", {62'h0, ram_ce, ram_we}, 64'h0);
    idle();

    // Reset lands on the write phase of a partial write.
    cyc(1, 1, 32'h28, 32'h000000EE, 4'b0001, 0, 0, 32'h0, 32'h0, 4'h0);
    check("rstrmw_rd", {62'h0, ram_ce, ram_we}, 64'h2);
    we_before = we_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    m0_req = 0;
    @(negedge clk);
    check("rstrmw_quiet", {62'h0, ram_ce, ram_we}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstrmw_wecnt", we_cnt, we_before);
    check("rstrmw_mem", {32'h0, mem[10]}, {32'h0, 32'h11223344});
    cyc(1, 0, 32'h00, 32'h0, 4'h0, 1, 0, 32'h04, 32'h0, 4'h0);
    check("rstrmw_rr", {62'h0, m1_gnt, m0_gnt}, 64'h1);
    sb.push_back('{1'b0, 32'hA0A00000});

    // Unaligned byte address reaches the RAM word-aligned.
    cyc(1, 0, 32'h23, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    check("align_addr", {32'h0, ram_addr}, 64'h20);
    sb.push_back('{1'b0, 32'hCAFEF00D});
    idle();
    idle();
    idle();

    check("sb_empty", sb.size(), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
